gpr_file_mp: RTL and testbench
==============================

GPR_FILE_MP -- requirements
Module: gpr_file_mp

Interface
REQ-001 SHALL take parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL take parameter NRD, default 4: number of read ports.
REQ-003 SHALL take parameter NWR, default 2: number of write ports.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port rd_addr  in  NRD*5: read addresses, port k in bits [5k+4:5k].
REQ-007 SHALL have port rd_data  out  NRD*DATA_W: read data, port k in slice k.
REQ-008 SHALL have port rd_busy  out  NRD: port k's register has a pending write.
REQ-009 SHALL have port wr_en  in  NWR: write enable per write port.
REQ-010 SHALL have port wr_addr  in  NWR*5: write addresses.
REQ-011 SHALL have port wr_data  in  NWR*DATA_W: write data.
REQ-012 SHALL have port hl_we  in  1: paired HI/LO write enable.
REQ-013 SHALL have port hl_wdata  in  2*DATA_W: {HI, LO} write data.
REQ-014 SHALL have port hi_data, lo_data  out  DATA_W each: current HI/LO, write-forwarded.
REQ-015 SHALL have port hl_busy  out  1: HI/LO pending write.
REQ-016 SHALL have port sb_set  in  1: issue-time reservation of sb_addr.
REQ-017 SHALL have port sb_addr  in  5: register being reserved.
REQ-018 SHALL have port sb_hl_set  in  1: issue-time reservation of HI/LO.
REQ-019 SHALL have port sb_flush  in  1: clear all reservations (pipeline flush).

Function
REQ-020 SHALL hold 32 GPRs; register 0 reads 0, ignores writes, and never becomes busy.
REQ-021 SHALL return on rd_data[k] combinationally: matching enabled write data if any write port hits rd_addr[k] in the same cycle, else the stored value.
REQ-022 SHALL resolve two write ports hitting the same address in one cycle with the highest-indexed port winning, for both storage and forwarding.
REQ-023 SHALL forward hl_wdata onto hi_data/lo_data in the cycle hl_we is high; store it at the edge.
REQ-024 SHALL set busy[a] at the edge when sb_set is high and sb_addr=a≠0.
REQ-025 SHALL clear busy[a] at the edge when any enabled write port addresses a.
REQ-026 SHALL give set priority when set and clear target the same register in one cycle (busy stays 1).
REQ-027 SHALL drive rd_busy[k] = busy[rd_addr[k]] AND NOT (same-cycle clearing write to that address); rd_busy is 0 for address 0.
REQ-028 SHALL manage hl_busy identically via sb_hl_set (set) and hl_we (clear), set winning.
REQ-029 SHALL, on sb_flush, clear every busy bit and hl_busy at the edge, overriding same-cycle sets; data writes in that cycle still commit.
REQ-030 SHALL have zero-cycle read latency and one-cycle write latency.

Reset
REQ-031 SHALL, while rst is low, asynchronously force all GPRs, HI, LO, every busy bit and hl_busy to 0; outputs then read 0 with rd_busy=0, hl_busy=0.
REQ-032 SHALL ignore writes and reservations while rst is low; the first edge after release behaves normally.

Structure
REQ-033 SHALL take from the shared package: REG_ZERO=5'd0, NUM_GPR=32, the GPR address width 5, and the default DATA_W.
REQ-034 SHALL use one sub-module, gpr_scoreboard, holding the busy vector and hl_busy with the set/clear/flush priority; storage and forwarding stay in gpr_file_mp.

Verification
REQ-035 SHALL cover write-through: wr_en[0]=1, wr_addr=5, wr_data=0x1234 with rd_addr[2]=5 -> rd_data[2]=0x1234 in the same cycle and 0x1234 stored afterwards.
REQ-036 SHALL cover port conflict: ports 0 and 1 both write r7 (0xAAAA, 0x5555) -> forwarded and stored value 0x5555.
REQ-037 SHALL cover register 0: write 0xFFFFFFFF to r0 with sb_set on r0 -> reads 0, rd_busy=0.
REQ-038 SHALL cover the scoreboard: sb_set r9 -> rd_busy=1 next cycle; write r9 with same-cycle sb_set r9 -> busy still 1; a plain write to r9 -> busy 0.
REQ-039 SHALL cover HI/LO: hl_we with 0x00000001_00000002 -> hi_data=1, lo_data=2 same cycle; sb_hl_set then sb_flush -> hl_busy back to 0.
REQ-040 SHALL cover reset mid-operation: rst low while r3=0x77 and busy[3]=1 -> r3 reads 0 and rd_busy=0 immediately, without a clock edge.

Source files
------------

// File: rtl/gpr_file_mp_pkg.sv
// gpr_file_mp_pkg: shared register-file constants
package gpr_file_mp_pkg;
  localparam int GPR_AW = 5;
  localparam int NUM_GPR = 32;
  localparam logic [GPR_AW-1:0] REG_ZERO = 5'd0;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: busy bits for the GPRs and HI/LO with flush > set > clear priority
module gpr_scoreboard
  import gpr_file_mp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               sb_set,
  input  logic [GPR_AW-1:0]  sb_addr,
  input  logic               sb_hl_set,
  input  logic               sb_flush,
  input  logic [NUM_GPR-1:0] clr,
  input  logic               hl_clr,
  output logic [NUM_GPR-1:0] busy,
  output logic               hl_busy
);
  logic [NUM_GPR-1:0] set_mask;
  assign set_mask = (sb_set && sb_addr != REG_ZERO) ? {{(NUM_GPR-1){1'b0}}, 1'b1} << sb_addr : '0;
  // reservations: flush wipes everything, otherwise a set beats a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= '0;
      hl_busy <= 1'b0;
    end else if (sb_flush) begin
      busy    <= '0;
      hl_busy <= 1'b0;
    end else begin
      busy    <= (busy & ~clr) | set_mask;
      hl_busy <= (hl_busy & ~hl_clr) | sb_hl_set;
    end
  end
endmodule

// File: rtl/gpr_file_mp.sv
// gpr_file_mp: multi-ported GPR file with HI/LO, write forwarding and issue scoreboard
module gpr_file_mp
  import gpr_file_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NRD    = 4,
  parameter int NWR    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*GPR_AW-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*GPR_AW-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  hl_we,
  input  logic [2*DATA_W-1:0]   hl_wdata,
  output logic [DATA_W-1:0]     hi_data,
  output logic [DATA_W-1:0]     lo_data,
  output logic                  hl_busy,
  input  logic                  sb_set,
  input  logic [GPR_AW-1:0]     sb_addr,
  input  logic                  sb_hl_set,
  input  logic                  sb_flush
);
  logic [DATA_W-1:0]  regs [NUM_GPR];
  logic [DATA_W-1:0]  hi, lo;
  logic [NWR-1:0]     wen;
  logic               hl_fwd;
  logic [NUM_GPR-1:0] clr, busy;
  // writes are inert while reset is held so outputs read zero
  assign wen    = rst ? wr_en : '0;
  assign hl_fwd = rst & hl_we;
  // registers being written this cycle; r0 is never tracked
  always_comb begin
    clr = '0;
    for (int p = 0; p < NWR; p++)
      if (wen[p]) clr[wr_addr[p*GPR_AW +: GPR_AW]] = 1'b1;
    clr[REG_ZERO] = 1'b0;
  end
  // storage; later write ports overwrite earlier ones on an address clash
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_GPR; i++) regs[i] <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (wen[p] && wr_addr[p*GPR_AW +: GPR_AW] != REG_ZERO)
          regs[wr_addr[p*GPR_AW +: GPR_AW]] <= wr_data[p*DATA_W +: DATA_W];
      if (hl_we) {hi, lo} <= hl_wdata;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [GPR_AW-1:0] a;
    logic [DATA_W-1:0] v;
    assign a = rd_addr[k*GPR_AW +: GPR_AW];
    // stored value, overridden by the highest-indexed same-cycle write to this address
    always_comb begin
      v = regs[a];
      for (int p = 0; p < NWR; p++)
        if (wen[p] && a != REG_ZERO && wr_addr[p*GPR_AW +: GPR_AW] == a)
          v = wr_data[p*DATA_W +: DATA_W];
    end
    assign rd_data[k*DATA_W +: DATA_W] = v;
    assign rd_busy[k] = busy[a] & ~clr[a];
  end
  assign hi_data = hl_fwd ? hl_wdata[2*DATA_W-1:DATA_W] : hi;
  assign lo_data = hl_fwd ? hl_wdata[DATA_W-1:0] : lo;
  gpr_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .sb_hl_set(sb_hl_set),
    .sb_flush (sb_flush),
    .clr      (clr),
    .hl_clr   (hl_fwd),
    .busy     (busy),
    .hl_busy  (hl_busy)
  );
endmodule

// File: tb/tb_gpr_file_mp.sv
// tb_gpr_file_mp: directed vectors with a queue-based expectation scoreboard
module tb_gpr_file_mp;
  localparam int W = 32, NRD = 4, NWR = 2;
  logic             clk = 1'b0;
  logic             rst;
  logic [NRD*5-1:0] rd_addr;
  logic [NRD*W-1:0] rd_data;
  logic [NRD-1:0]   rd_busy;
  logic [NWR-1:0]   wr_en;
  logic [NWR*5-1:0] wr_addr;
  logic [NWR*W-1:0] wr_data;
  logic             hl_we;
  logic [2*W-1:0]   hl_wdata;
  logic [W-1:0]     hi_data, lo_data;
  logic             hl_busy;
  logic             sb_set, sb_hl_set, sb_flush;
  logic [4:0]       sb_addr;

  gpr_file_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .hl_we(hl_we), .hl_wdata(hl_wdata),
    .hi_data(hi_data), .lo_data(lo_data), .hl_busy(hl_busy), .sb_set(sb_set), .sb_addr(sb_addr),
    .sb_hl_set(sb_hl_set), .sb_flush(sb_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    int          port;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];
  int nvec = 0, nerr = 0;

  function automatic logic [31:0] observe(int sel, int port);
    case (sel)
      0:       return rd_data[port*W +: W];
      1:       return {31'd0, rd_busy[port]};
      2:       return hi_data;
      3:       return lo_data;
      default: return {31'd0, hl_busy};
    endcase
  endfunction

  // monitor: compare all expectations queued for this cycle at the falling edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = observe(e.sel, e.port);
      nvec++;
      if (act !== e.val) begin
        nerr++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic ex(string n, int sel, int port, logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = sel; e.port = port; e.val = v;
    q.push_back(e);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wr_en = '0; hl_we = 0; sb_set = 0; sb_hl_set = 0; sb_flush = 0;
  endtask
  task automatic wr(int p, logic [4:0] a, logic [31:0] d);
    wr_en[p] = 1'b1; wr_addr[p*5 +: 5] = a; wr_data[p*W +: W] = d;
  endtask
  task automatic rd(int k, logic [4:0] a);
    rd_addr[k*5 +: 5] = a;
  endtask

  initial begin
    rst = 0; rd_addr = '0; wr_addr = '0; wr_data = '0; hl_wdata = '0; sb_addr = '0;
    idle();
    cyc();
    wr(0, 1, 32'hDEAD); sb_set = 1; sb_addr = 1; rd(0, 1);
    ex("rst_rd0", 0, 0, 0); ex("rst_busy0", 1, 0, 0); ex("rst_hi", 2, 0, 0);
    ex("rst_lo", 3, 0, 0); ex("rst_hlbusy", 4, 0, 0);
    cyc();
    rst = 1; idle();
    ex("rst_write_ignored", 0, 0, 0); ex("rst_set_ignored", 1, 0, 0);
    cyc();
    wr(0, 5, 32'h1234); rd(2, 5);
    ex("wthru_fwd", 0, 2, 32'h1234);
    cyc(); idle();
    ex("wthru_stored", 0, 2, 32'h1234);
    cyc();
    wr(0, 7, 32'hAAAA); wr(1, 7, 32'h5555); rd(1, 7);
    ex("conflict_fwd", 0, 1, 32'h5555);
    cyc(); idle();
    ex("conflict_stored", 0, 1, 32'h5555);
    cyc();
    wr(0, 0, 32'hFFFFFFFF); sb_set = 1; sb_addr = 0; rd(3, 0);
    ex("r0_fwd", 0, 3, 0); ex("r0_busy_now", 1, 3, 0);
    cyc(); idle();
    ex("r0_stored", 0, 3, 0); ex("r0_busy", 1, 3, 0);
    cyc();
    sb_set = 1; sb_addr = 9; rd(0, 9);
    ex("sb_pre_set", 1, 0, 0);
    cyc(); idle();
    ex("sb_set_r9", 1, 0, 1);
    cyc();
    wr(0, 9, 32'h99); sb_set = 1; sb_addr = 9;
    ex("sb_clear_masked", 1, 0, 0); ex("sb_wr_fwd", 0, 0, 32'h99);
    cyc(); idle();
    ex("sb_set_wins", 1, 0, 1); ex("sb_wr_stored", 0, 0, 32'h99);
    cyc();
    wr(1, 9, 32'h100);
    ex("sb_clear_same", 1, 0, 0);
    cyc(); idle();
    ex("sb_cleared", 1, 0, 0); ex("sb_wr2_stored", 0, 0, 32'h100);
    cyc();
    hl_we = 1; hl_wdata = 64'h00000001_00000002;
    ex("hl_fwd_hi", 2, 0, 1); ex("hl_fwd_lo", 3, 0, 2); ex("hl_busy_idle", 4, 0, 0);
    cyc(); idle(); sb_hl_set = 1;
    ex("hl_hi_stored", 2, 0, 1); ex("hl_lo_stored", 3, 0, 2); ex("hl_busy_pre", 4, 0, 0);
    cyc(); idle(); sb_flush = 1; sb_set = 1; sb_addr = 11;
    ex("hl_busy_set", 4, 0, 1);
    cyc(); idle(); rd(0, 11);
    ex("flush_hl", 4, 0, 0); ex("flush_over_set", 1, 0, 0);
    cyc(); sb_hl_set = 1;
    cyc(); idle(); hl_we = 1; hl_wdata = 64'h00000003_00000004;
    ex("hl_busy_reg", 4, 0, 1); ex("hl_fwd_hi2", 2, 0, 3); ex("hl_fwd_lo2", 3, 0, 4);
    cyc(); idle(); hl_we = 1; sb_hl_set = 1;
    ex("hl_clear_we", 4, 0, 0);
    cyc(); idle();
    ex("hl_set_wins", 4, 0, 1);
    cyc();
    wr(0, 3, 32'h77); sb_set = 1; sb_addr = 3; rd(0, 3); rd(2, 5);
    cyc(); idle();
    ex("pre_rst_r3", 0, 0, 32'h77); ex("pre_rst_busy3", 1, 0, 1);
    cyc();
    rst = 0;
    ex("async_rst_r3", 0, 0, 0); ex("async_rst_busy3", 1, 0, 0);
    ex("async_rst_hl", 4, 0, 0); ex("async_rst_hi", 2, 0, 0);
    cyc();
    rst = 1;
    ex("post_rst_r5", 0, 2, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked, required 0", q.size());
      nerr += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
